// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and writeback.
// Latency: outputs are combinational from state (plus Op/mem_ready/Zero); state advances one per clk.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready is low. Optional macro: RISCV_ILLEGAL_OP_EN.
module riscv_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  localparam logic [6:0] LOAD   = 7'd3;
  localparam logic [6:0] I_AL   = 7'd19;
  localparam logic [6:0] AUIPC  = 7'd23;
  localparam logic [6:0] STORE  = 7'd35;
  localparam logic [6:0] REG    = 7'd51;
  localparam logic [6:0] LUI    = 7'd55;
  localparam logic [6:0] BRANCH = 7'd99;
  localparam logic [6:0] JALR   = 7'd103;
  localparam logic [6:0] JAL    = 7'd111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JALRADR  = 4'd10,
    S_JUMP     = 4'd11,
    S_LUIWB    = 4'd12,
    S_AUIPCEX  = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  state_t r_state;
  logic   w_uncond_pc;

  // State register and next-state selection; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            LOAD, STORE: r_state <= S_MEMADR;
            REG:         r_state <= S_EXECR;
            I_AL:        r_state <= S_EXECI;
            BRANCH:      r_state <= S_BEQ;
            JAL:         r_state <= S_JUMP;
            JALR:        r_state <= S_JALRADR;
            LUI:         r_state <= S_LUIWB;
            AUIPC:       r_state <= S_AUIPCEX;
`ifdef RISCV_ILLEGAL_OP_EN
            default:     r_state <= S_ILLEGAL;
`else
            default:     r_state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR:   r_state <= (Op == STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BEQ:      r_state <= S_FETCH;
        S_JALRADR:  r_state <= S_JUMP;
        S_JUMP:     r_state <= S_ALUWB;
        S_LUIWB:    r_state <= S_FETCH;
        S_AUIPCEX:  r_state <= S_ALUWB;
`ifdef RISCV_ILLEGAL_OP_EN
        S_ILLEGAL:  r_state <= S_ILLEGAL;
`endif
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; anything not named for a state stays 0.
  always_comb begin
    w_uncond_pc = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    Branch      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    ResultSrc   = 2'b00;
    ImmSrc      = 3'b000;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        IRWrite     = mem_ready;
        w_uncond_pc = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (Op == JAL) ? 3'b100 : 3'b010;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (Op == STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_JUMP: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_uncond_pc = 1'b1;
      end
      S_LUIWB: begin
        ImmSrc    = 3'b011;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      S_AUIPCEX: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b011;
      end
`ifdef RISCV_ILLEGAL_OP_EN
      S_ILLEGAL:  illegal = 1'b1;
`endif
      default: ;
    endcase
    PCWrite = w_uncond_pc | (Branch & Zero);
  end

endmodule
